gauss_unit_arbiter: RTL and testbench

Shares one Gauss functional unit among N_REQ reservation-station requesters. Grants access round-robin, sequences the datapath through start/done, and returns each result with its tag on the common data bus (CDB). A watchdog aborts hung operations. It sits between the issue stage and the Gauss datapath/control unit.

---
 rtl/gauss_unit_arbiter.sv | 156 +++++++++++++++
 tb/tb_gauss_unit_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_unit_arbiter.sv
// gauss_unit_arbiter: round-robin sharing of one Gauss functional unit among
// N_REQ reservation-station requesters. One operation in flight at a time:
// accept -> start pulse -> wait for done (or watchdog abort) -> CDB writeback.
module gauss_unit_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      preset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_operand,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fu_start,
  output logic [DATA_W-1:0]         fu_operand,
  input  logic                      fu_done,
  input  logic [DATA_W-1:0]         fu_result,
  output logic                      fu_preset,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_err,
  input  logic                      cdb_ready,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_gnt;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_fu_start;
  logic                  w_fu_preset;
  logic [WD_W-1:0]       r_wdog;
  logic [DATA_W-1:0]     r_operand;
  logic [DATA_W-1:0]     r_result;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_err;

  // Round-robin winner: first valid requester at or above ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Next-state and per-state pulses; done wins over a simultaneous timeout.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_fu_start  = 1'b0;
    w_fu_preset = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_fu_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (fu_done) begin
          w_next = S_WB;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_fu_preset = 1'b1;
          w_next      = S_WB;
        end
      end
      S_WB: begin
        if (cdb_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pointer moves just past the requester that was served.
  assign w_ptr_nxt = (r_gnt == PTR_W'(N_REQ - 1)) ? '0 : r_gnt + PTR_W'(1);

  // State register and round-robin pointer.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WB && cdb_ready) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Transaction registers: latched request, watchdog, captured result.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_operand <= '0;
      r_tag     <= '0;
      r_gnt     <= '0;
      r_wdog    <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_operand <= req_operand[w_win*DATA_W +: DATA_W];
        r_tag     <= req_tag[w_win*TAG_W +: TAG_W];
        r_gnt     <= w_win;
      end
      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end
      if (r_state == S_WAIT) begin
        r_wdog <= r_wdog + WD_W'(1);
        if (fu_done) begin
          r_result <= fu_result;
          r_err    <= 1'b0;
        end else if (w_fu_preset) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE && w_found) ? (N_REQ'(1) << w_win) : '0;
  assign fu_start   = w_fu_start;
  assign fu_preset  = w_fu_preset;
  assign fu_operand = r_operand;
  assign cdb_valid  = (r_state == S_WB);
  assign cdb_tag    = r_tag;
  assign cdb_data   = r_result;
  assign cdb_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_gauss_unit_arbiter.sv
// Directed testbench for gauss_unit_arbiter (N_REQ=4, DATA_W=16, TAG_W=4, TIMEOUT=8).
module tb_gauss_unit_arbiter;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_operand = '0;
  logic [15:0] req_tag = '0;
  logic [3:0]  req_ready;
  logic        fu_start;
  logic [15:0] fu_operand;
  logic        fu_done = 1'b0;
  logic [15:0] fu_result = '0;
  logic        fu_preset;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        cdb_err;
  logic        cdb_ready = 1'b0;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  gauss_unit_arbiter #(.N_REQ(4), .DATA_W(16), .TAG_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .preset(preset),
    .req_valid(req_valid), .req_operand(req_operand), .req_tag(req_tag), .req_ready(req_ready),
    .fu_start(fu_start), .fu_operand(fu_operand), .fu_done(fu_done), .fu_result(fu_result),
    .fu_preset(fu_preset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_err(cdb_err),
    .cdb_ready(cdb_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_chk++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid got=%0b want=0", cdb_valid); end
    n_chk++; if (fu_start !== 1'b0) begin n_fail++; $display("FAIL reset_fu_start got=%0b want=0", fu_start); end
    n_chk++; if (fu_preset !== 1'b0) begin n_fail++; $display("FAIL reset_fu_preset got=%0b want=0", fu_preset); end
    n_chk++; if (fu_operand !== 16'd0) begin n_fail++; $display("FAIL reset_fu_operand got=%0d want=0", fu_operand); end
    n_chk++; if (cdb_data !== 16'd0 || cdb_tag !== 4'd0 || cdb_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_cdb got=%0d/%0d/%0b want=0/0/0", cdb_data, cdb_tag, cdb_err); end
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle got=%b want=0000", req_ready); end
    req_valid = 4'b0100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL reset_ready_rule got=%b want=0100", req_ready); end
    req_valid = 4'b0000;
    tick();
    tick();
    preset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_operand[15:0] = 16'd10;
    req_tag[3:0] = 4'd3;
    cdb_ready = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    n_chk++; if (fu_start !== 1'b0) begin n_fail++; $display("FAIL single_start_idle got=%0b want=0", fu_start); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_chk++; if (fu_start !== 1'b1 || fu_operand !== 16'd10)
      begin n_fail++; $display("FAIL single_issue got start=%0b op=%0d want start=1 op=10", fu_start, fu_operand); end
    n_chk++; if (req_ready !== 4'b0000 || busy !== 1'b1)
      begin n_fail++; $display("FAIL single_issue_ctl got ready=%b busy=%0b want 0000/1", req_ready, busy); end
    for (int w = 1; w <= 4; w++) begin
      tick();
      n_chk++; if (fu_start !== 1'b0 || cdb_valid !== 1'b0)
        begin n_fail++; $display("FAIL single_wait%0d got start=%0b cdbv=%0b want 0/0", w, fu_start, cdb_valid); end
    end
    tick();
    fu_done = 1'b1;
    fu_result = 16'd55;
    tick();
    fu_done = 1'b0;
    fu_result = 16'd0;
    #1;
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3 || cdb_data !== 16'd55 || cdb_err !== 1'b0)
      begin n_fail++; $display("FAIL single_cdb got v=%0b tag=%0d data=%0d err=%0b want 1/3/55/0", cdb_valid, cdb_tag, cdb_data, cdb_err); end
    tick();
    n_chk++; if (cdb_valid !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL single_done got cdbv=%0b busy=%0b want 0/0", cdb_valid, busy); end
  endtask

  task automatic test_round_robin();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    req_valid = 4'b1111;
    req_operand = {16'd103, 16'd102, 16'd101, 16'd100};
    req_tag = {4'd11, 4'd10, 4'd9, 4'd8};
    fu_done = 1'b1;
    fu_result = 16'h1234;
    cdb_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % 4;
      #1;
      n_chk++; if (req_ready !== (4'b0001 << e))
        begin n_fail++; $display("FAIL rr_grant%0d got=%b want=%b", g, req_ready, 4'b0001 << e); end
      tick();
      n_chk++; if (fu_start !== 1'b1 || fu_operand !== 16'(100 + e))
        begin n_fail++; $display("FAIL rr_issue%0d got start=%0b op=%0d want 1/%0d", g, fu_start, fu_operand, 100 + e); end
      tick();
      tick();
      n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(8 + e) || cdb_data !== 16'h1234)
        begin n_fail++; $display("FAIL rr_cdb%0d got v=%0b tag=%0d data=%h want 1/%0d/1234", g, cdb_valid, cdb_tag, cdb_data, 8 + e); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    req_valid = 4'b1111;
    fu_done = 1'b1;
    fu_result = 16'hBEEF;
    cdb_ready = 1'b0;
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got=%b want=0010", req_ready); end
    tick();
    tick();
    tick();
    fu_done = 1'b0;
    fu_result = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd9 || cdb_data !== 16'hBEEF || req_ready !== 4'b0000)
        begin n_fail++; $display("FAIL bp_hold%0d got v=%0b tag=%0d data=%h ready=%b want 1/9/beef/0000", c, cdb_valid, cdb_tag, cdb_data, req_ready); end
      tick();
      fu_result = 16'(c + 1);
    end
    cdb_ready = 1'b1;
    #1;
    n_chk++; if (cdb_valid !== 1'b1 || cdb_data !== 16'hBEEF)
      begin n_fail++; $display("FAIL bp_release got v=%0b data=%h want 1/beef", cdb_valid, cdb_data); end
    tick();
    n_chk++; if (cdb_valid !== 1'b0 || req_ready !== 4'b0100)
      begin n_fail++; $display("FAIL bp_after got v=%0b ready=%b want 0/0100", cdb_valid, req_ready); end
  endtask

  task automatic test_timeout();
    req_valid = 4'b1111;
    fu_done = 1'b0;
    cdb_ready = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL to_grant got=%b want=0100", req_ready); end
    tick();
    n_chk++; if (fu_preset !== 1'b0) begin n_fail++; $display("FAIL to_issue_preset got=%0b want=0", fu_preset); end
    tick();
    for (int w = 1; w <= 8; w++) begin
      n_chk++; if (fu_preset !== (w == 8) || cdb_valid !== 1'b0)
        begin n_fail++; $display("FAIL to_wait%0d got preset=%0b cdbv=%0b want %0b/0", w, fu_preset, cdb_valid, (w == 8)); end
      tick();
    end
    n_chk++; if (cdb_valid !== 1'b1 || cdb_err !== 1'b1 || cdb_data !== 16'd0 || cdb_tag !== 4'd10 || fu_preset !== 1'b0)
      begin n_fail++; $display("FAIL to_cdb got v=%0b err=%0b data=%0d tag=%0d pr=%0b want 1/1/0/10/0", cdb_valid, cdb_err, cdb_data, cdb_tag, fu_preset); end
    tick();
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL to_next_grant got=%b want=1000", req_ready); end
  endtask

  task automatic test_collision();
    req_valid = 4'b1111;
    fu_done = 1'b0;
    tick();
    tick();
    for (int w = 1; w <= 7; w++) tick();
    fu_done = 1'b1;
    fu_result = 16'h0077;
    #1;
    n_chk++; if (fu_preset !== 1'b0) begin n_fail++; $display("FAIL col_preset got=%0b want=0", fu_preset); end
    tick();
    fu_done = 1'b0;
    n_chk++; if (cdb_valid !== 1'b1 || cdb_err !== 1'b0 || cdb_data !== 16'h0077 || cdb_tag !== 4'd11)
      begin n_fail++; $display("FAIL col_cdb got v=%0b err=%0b data=%h tag=%0d want 1/0/0077/11", cdb_valid, cdb_err, cdb_data, cdb_tag); end
    tick();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0010;
    fu_done = 1'b1;
    fu_result = 16'h0001;
    tick();
    tick();
    tick();
    tick();
    req_valid = 4'b1000;
    fu_done = 1'b0;
    #1;
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL ar_grant got=%b want=1000", req_ready); end
    tick();
    tick();
    tick();
    #2;
    preset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || fu_operand !== 16'd0 || cdb_valid !== 1'b0 || fu_preset !== 1'b0 || fu_start !== 1'b0)
      begin n_fail++; $display("FAIL ar_clear got busy=%0b op=%0d cdbv=%0b pr=%0b st=%0b want 0/0/0/0/0", busy, fu_operand, cdb_valid, fu_preset, fu_start); end
    fu_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (cdb_valid !== 1'b0 || fu_preset !== 1'b0)
        begin n_fail++; $display("FAIL ar_hold%0d got cdbv=%0b pr=%0b want 0/0", c, cdb_valid, fu_preset); end
    end
    #2;
    preset = 1'b0;
    req_valid = 4'b1010;
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL ar_regrant got=%b want=0010", req_ready); end
    tick();
    n_chk++; if (fu_operand !== 16'd101) begin n_fail++; $display("FAIL ar_operand got=%0d want=101", fu_operand); end
    tick();
    tick();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd9)
      begin n_fail++; $display("FAIL ar_cdb got v=%0b tag=%0d want 1/9", cdb_valid, cdb_tag); end
    tick();
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL ar_pending got=%b want=1000", req_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
